// File: rtl/fetch_unit_if.sv
// AXI4 read-address and read-data channel bundle between the fetch unit and memory.
//   master: fetch side. It drives AR and rready, and receives arready and the R channel.
//   slave : memory side. It is the mirror image of master.
interface fetch_unit_if #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It fetches one 64-byte line as an 8-beat AXI WRAP burst into a
// 16-word line buffer. It then presents one instruction and its PC per valid/ready handshake.
// A redirect flushes the buffer and restarts fetch; any burst already in flight is drained.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   entry           : first fetch PC, taken on the first clock after reset
//   redirect_valid  : branch/jump redirect strobe
//   redirect_pc     : redirect target; bits [1:0] are ignored
//   out_valid/ready : handshake for the instruction output
//   out_pc/out_inst : PC and instruction word
//   fetch_error     : sticky flag, set by any non-OKAY read response
//   axi             : AXI read channels (master side)
module fetch_unit #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [31:0]           out_inst,
    output logic                  fetch_error,
    fetch_unit_if.master          axi
);

    typedef enum logic [2:0] {StIdle, StReq, StData, StServe, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            beat_valid_q, beat_valid_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic                  redir_pend_q, redir_pend_d;  // redirect seen while AR still pending
    logic                  err_q, err_d;
    logic [31:0]           line_q [16];

    logic [DATA_WIDTH-1:0] rdata;
    logic [3:0]            idx;
    logic                  beat_acc;
    logic                  last_acc;
    logic                  handshake;
    logic                  unused_ok;

    assign rdata     = axi.m_axi_rdata;
    assign idx       = pc_q[5:2];
    assign beat_acc  = axi.m_axi_rvalid && axi.m_axi_rready;
    assign last_acc  = beat_acc && axi.m_axi_rlast;
    assign handshake = out_valid && out_ready;
    assign unused_ok = ^{axi.m_axi_rid, redirect_pc[1:0]};

    // Constant AR attributes: one 8 x 8-byte WRAP burst per line.
    assign axi.m_axi_arid    = {ID_WIDTH{1'b0}};
    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arlen   = 8'd7;
    assign axi.m_axi_arsize  = 3'd3;
    assign axi.m_axi_arburst = 2'b10;
    assign axi.m_axi_arlock  = 1'b0;
    assign axi.m_axi_arcache = 4'd0;
    assign axi.m_axi_arprot  = 3'b110;
    assign axi.m_axi_arvalid = (state_q == StReq);
    assign axi.m_axi_rready  = (state_q == StData) || (state_q == StDrain);

    assign out_pc      = pc_q;
    assign out_inst    = line_q[idx];
    assign fetch_error = err_q;
    assign out_valid   = ((state_q == StData) || (state_q == StServe)) &&
                         beat_valid_q[idx[3:1]] && !err_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        araddr_d     = araddr_q;
        beat_valid_d = beat_valid_q;
        beat_cnt_d   = beat_cnt_q;
        redir_pend_d = redir_pend_q;
        err_d        = err_q;

        if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + 3'd1;
            if (state_q == StData) begin
                beat_valid_d[beat_cnt_q] = 1'b1;
            end
            if (axi.m_axi_rresp != 2'b00) begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                pc_d    = entry;
                state_d = StReq;
            end
            StReq: begin
                if (axi.m_axi_arready) begin
                    beat_valid_d = '0;
                    beat_cnt_d   = '0;
                    redir_pend_d = 1'b0;
                    state_d      = redir_pend_q ? StDrain : StData;
                end
            end
            StData: begin
                if (handshake) begin
                    pc_d = pc_q + ADDR_WIDTH'(4);
                end
                if (last_acc) begin
                    state_d = StServe;
                end
            end
            StServe: begin
                if (handshake) begin
                    pc_d = pc_q + ADDR_WIDTH'(4);
                    if (idx == 4'd15) begin
                        state_d = StReq;
                    end
                end
            end
            StDrain: begin
                if (last_acc) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides any same-cycle handshake increment.
        if (redirect_valid) begin
            pc_d         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            beat_valid_d = '0;
            case (state_q)
                StIdle, StServe: state_d = StReq;
                StData, StDrain: state_d = last_acc ? StReq : StDrain;
                StReq: begin
                    if (axi.m_axi_arready) begin
                        state_d = StDrain;
                    end else begin
                        redir_pend_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // The AR address is latched on entry to REQ and stays stable until it is accepted.
        if ((state_d == StReq) && (state_q != StReq)) begin
            araddr_d = {pc_d[ADDR_WIDTH-1:6], 6'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            araddr_q     <= '0;
            beat_valid_q <= '0;
            beat_cnt_q   <= '0;
            redir_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            beat_valid_q <= beat_valid_d;
            beat_cnt_q   <= beat_cnt_d;
            redir_pend_q <= redir_pend_d;
            err_q        <= err_d;
        end
    end

    // Line storage needs no reset; beat_valid qualifies every read of it.
    always_ff @(posedge clk) begin
        if ((state_q == StData) && beat_acc) begin
            line_q[{beat_cnt_q, 1'b0}] <= rdata[31:0];
            line_q[{beat_cnt_q, 1'b1}] <= rdata[63:32];
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the IF/ID pipeline register. Fetches 64-byte instruction lines over the AXI read channel as 8-beat bursts into a 16-entry line buffer, then delivers one 32-bit instruction plus its PC per valid/ready handshake. Supports redirect (branch/jump target) with flush, draining any in-flight burst. Replaces the ad-hoc fetch state machine in the core top level.

## Interface
- ID_WIDTH, 13, AXI ID width
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI data width; fixed at 64 for this block
---
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- entry  in  64  first fetch PC, sampled on first clock after reset deasserts
- redirect_valid  in  1  flush buffer and restart fetch at redirect_pc
- redirect_pc  in  64  new PC; bits [1:0] ignored (treated as 0)
- out_valid  out  1  out_pc/out_inst valid
- out_ready  in  1  downstream accepts instruction
- out_pc  out  64  PC of out_inst
- out_inst  out  32  instruction word
- fetch_error  out  1  sticky; set on any non-OKAY rresp
- m_axi_arid / araddr / arlen / arsize / arburst / arlock / arcache / arprot / arvalid  out  13/64/8/3/2/1/4/3/1  AXI AR channel
- m_axi_arready  in  1
- m_axi_rid / rdata / rresp / rlast / rvalid  in  13/64/2/1/1  AXI R channel
- m_axi_rready  out  1

## Operation
- Constant AR fields: arid 0, arlen 7, arsize 3, arburst 2 (WRAP), arlock 0, arcache 0, arprot 6. araddr = {pc[63:6], 6'b0} (line-aligned, so WRAP order = beats 0..7).
- Buffer: 16 x 32-bit; beat k writes entry 2k (rdata[31:0]) and 2k+1 (rdata[63:32]); beat_valid[7:0] set per received beat, cleared on new request.
- idx = pc[5:2]. out_inst = buf[idx], out_pc = pc. out_valid = (state DATA or SERVE) && beat_valid[idx>>1] && !fetch_error.
- Handshake (out_valid && out_ready, no redirect): pc <= pc+4. If idx was 15: go REQ for the next line.
- States:
  - IDLE: entered on reset. Next clock: pc <= entry, -> REQ.
  - REQ: arvalid=1, araddr stable. On arready: arvalid<=0, clear beat_valid, -> DATA.
  - DATA: rready=1; record beats; on rvalid&&rlast -> SERVE. Serving allowed during DATA (critical-word use).
  - SERVE: rready=0, arvalid=0; serve until idx wraps 15->0, then -> REQ.
  - DRAIN: rready=1, discard beats; on rvalid&&rlast -> REQ.
- Redirect (priority over handshake same cycle; that handshake's pc increment is discarded, downstream must drop that instruction): pc <= {redirect_pc[63:2],2'b0}; beat_valid cleared; out_valid drops next cycle. Next state: from SERVE/IDLE -> REQ; from DATA -> DRAIN (or -> REQ if rlast accepted same cycle); from REQ with arready same cycle -> DRAIN; from REQ without arready -> stay REQ but must complete the pending AR (araddr unchanged until accepted), then DRAIN; from DRAIN -> stay DRAIN.
- rresp != 0 on any accepted beat: fetch_error <= 1, sticky until reset; out_valid held 0; bursts still drained normally.

## Timing
- Reset (async) values: state IDLE, arvalid 0, araddr 0, rready 0, out_valid 0, out_pc 0, fetch_error 0, beat_valid 0.
- Edge 1 after reset deassert: pc<=entry; edge 2: arvalid high visible.
- Latency: beat containing idx accepted at edge N -> out_valid high after edge N (registered buffer, combinational out mux).
- Throughput: one instruction/clock in SERVE with out_ready held; 1-cycle bubble minimum at line boundary plus AXI latency.
- arvalid never drops before arready; rready constant through a burst.

## Test plan
- Reset with entry=0x1000, memory line of 16 words 0x00000013+i -> AR araddr 0x1000 len 7 burst 2; outputs pc 0x1000..0x103C, inst 0x13..0x22 in order, then AR for 0x1040.
- entry=0x1038 -> araddr 0x1000; first out_pc 0x1038 appears after beat 7; after 0x103C next AR 0x1040.
- out_ready low 5 cycles mid-line -> out_pc/out_inst held stable, no AR issued, no instruction lost.
- redirect_valid with redirect_pc=0x2004 during beat 3 of a burst -> remaining beats discarded (rready high to rlast), next AR 0x2000, first out_pc 0x2004.
- redirect while arvalid high and arready low -> araddr unchanged until accepted, burst drained, then AR for redirect line.
- Beat with rresp=2 -> fetch_error 1 and out_valid 0 until reset; async reset mid-burst clears all outputs immediately.
